alu_out_result_tx: RTL
======================

// Module: alu_out_result_tx
// PURPOSE
//  - Transmitter (driving end) of the alu_out protocol: produces done/result toward alu_out_if.
//  - The ALU datapath hands completed results over a valid/ready port. Results are buffered
//    in a small FIFO and emitted as single-cycle done pulses, with the result valid in the
//    same cycle as done.
//  - A runtime-programmable minimum idle gap is enforced between pulses.
// PARAMETERS
//  ALU_OUT_RESULT_WIDTH  16  width of in_result / result
//  FIFO_DEPTH            4   result buffer entries; power of 2, >=2
// PORTS
//  clk         in   1      clock; all logic on posedge
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      ALU core presents in_result
//  in_ready    out  1      buffer can accept; = !fifo_full
//  in_result   in   W      result from ALU core, W = ALU_OUT_RESULT_WIDTH
//  gap_cycles  in   4      minimum done-low cycles between pulses; 0 = back-to-back allowed
//  done        out  1      one-cycle pulse per result (alu_out_if.done)
//  result      out  W      valid while done=1 (alu_out_if.result)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
//  tx_count    out  16     pulses sent; port exists only with ALU_OUT_TX_STATS_EN
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
//  - Reset values: done=0, result=0, fifo_level=0, in_ready=1 on the first cycle after reset;
//    state IDLE; gap counter 0; tx_count=0.
//  - Reset mid-operation: FIFO flushed, a pending gap is abandoned, done=0 on the next cycle.
//    No partial pulse is ever produced.
//  - Push: in_valid && in_ready at posedge.
//    - Full: in_ready=0. A push is refused even when a pop happens in the same cycle;
//      in_ready rises the cycle after a pop frees an entry.
//  - Registered outputs. Latency: in_valid accepted at edge N -> done=1 in the cycle after
//    edge N+2, i.e. 2 cycles from an empty, IDLE start.
//  - FSM (enum in package):
//    - IDLE: done=0. If FIFO non-empty -> pop head into result, done<=1, go PULSE.
//    - PULSE: done=1 for exactly one cycle. Sample gap_cycles here.
//      - gap_cycles==0 and FIFO non-empty -> pop next, stay PULSE (back-to-back pulses).
//      - gap_cycles==0 and FIFO empty -> IDLE.
//      - gap_cycles>0 -> load gap counter = gap_cycles, go GAP.
//    - GAP: done=0; counter decrements each cycle.
//      - On the cycle the counter reaches 0: if FIFO non-empty, pop and go PULSE,
//        giving exactly gap_cycles low cycles; otherwise go IDLE.
//  - result holds its last transmitted value while done=0. It changes only on a pop.
//  - done never stays high two cycles for the same entry. Each pop yields exactly one pulse.
//  - gap_cycles changes take effect at the next PULSE; an in-progress GAP is not affected.
//  - FIFO pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH, with push and pop
//    in the same cycle leaving it unchanged.
// CONFIGURATION
//  - ALU_OUT_TX_STATS_EN defined:
//    - 16-bit tx_count increments on each cycle with done=1 and wraps 0xFFFF->0.
//    - rst clears it.
//  - Not defined: no tx_count port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  - Package alu_out_tx_pkg holds:
//    - typedef enum logic [1:0] {IDLE, PULSE, GAP} alu_out_tx_state_t;
//    - localparam int ALU_OUT_GAP_WIDTH = 4;
//  - Sub-module alu_out_result_fifo: synchronous FIFO with push/pop/full/empty/level.
//    Parameterised by width and depth; reset via rst.
//  - Top level holds the FSM, gap counter, output registers and the optional stats counter.
// TESTING
//  1. Single result: gap=0; push 0x1234 -> done=1 for exactly one cycle, 2 cycles later,
//     with result=0x1234; then done=0 and result holds 0x1234.
//  2. Back-to-back: gap=0; push 0x0001..0x0004 on consecutive cycles -> 4 consecutive done
//     cycles carrying 1,2,3,4 in order.
//  3. Gap: gap=3; push 5 results -> exactly 3 done-low cycles between each pulse; data in order.
//  4. Full: hold in_valid with 6 values while gap=15 -> in_ready=0 at level 4. No value is lost
//     or duplicated; done pulses total 6.
//  5. Reset mid-GAP, with 2 entries queued -> done=0, level=0, in_ready=1 next cycle.
//     No pulse is emitted until a new push.
//  6. With ALU_OUT_TX_STATS_EN: preload near wrap by sending 65537 pulses -> tx_count=1;
//     rst -> 0.

Source files
------------

// File: rtl/alu_out_tx_pkg.sv
// Shared types for the alu_out result transmitter: FSM state encoding and gap counter width.
package alu_out_tx_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} alu_out_tx_state_t;
  localparam int ALU_OUT_GAP_WIDTH = 4;
endpackage

// File: rtl/alu_out_result_fifo.sv
// Synchronous FIFO buffering ALU results ahead of the done-pulse generator.
// Head entry is presented combinationally on rdata; level counts 0..DEPTH.
module alu_out_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/alu_out_result_tx.sv
// Driving end of alu_out: buffers ALU results and emits one-cycle done pulses with a
// programmable minimum idle gap. Define ALU_OUT_TX_STATS_EN to add the tx_count port.
module alu_out_result_tx
  import alu_out_tx_pkg::*;
#(
  parameter int ALU_OUT_RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH           = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ALU_OUT_RESULT_WIDTH-1:0] in_result,
  input  logic [ALU_OUT_GAP_WIDTH-1:0]    gap_cycles,
  output logic                            done,
  output logic [ALU_OUT_RESULT_WIDTH-1:0] result,
  output logic [LW-1:0]                   fifo_level
`ifdef ALU_OUT_TX_STATS_EN
  ,
  output logic [15:0]                     tx_count
`endif
);
  alu_out_tx_state_t              state, state_n;
  logic [ALU_OUT_GAP_WIDTH-1:0]   gap_cnt, gap_n;
  logic [ALU_OUT_RESULT_WIDTH-1:0] head, data_q;
  logic                           full, empty, pop;

  assign in_ready = !full;

  alu_out_result_fifo #(
    .WIDTH (ALU_OUT_RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_result),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (gap_cycles == '0) begin
          pop     = !empty;
          state_n = empty ? IDLE : PULSE;
        end else begin
          gap_n   = gap_cycles;
          state_n = GAP;
        end
      end
      GAP: begin
        gap_n = gap_cnt - 1'b1;
        // Last low cycle: pop now so the next pulse lands after exactly gap_cycles lows.
        if (gap_cnt <= 1) begin
          pop     = !empty;
          state_n = empty ? IDLE : PULSE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      if (pop) data_q <= head;
    end
  end

  // Output stage: PULSE state is mirrored one cycle later onto done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == PULSE);
      if (state == PULSE) result <= data_q;
    end
  end

`ifdef ALU_OUT_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)       tx_count <= '0;
    else if (done) tx_count <= tx_count + 16'd1;
  end
`endif
endmodule
